// File: rtl/drop_controller.sv
// Cursor, drop-request and column-height control for a four-column drop game.
// All outputs come straight from registers; buttons are edge-detected internally.

module drop_col_height #(
  parameter int ROWS = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] count
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        count <= 3'd0;
    else if (clr)                        count <= 3'd0;
    else if (inc && count < 3'(ROWS))    count <= count + 3'd1;
  end
endmodule

module drop_controller #(
  parameter int ROWS = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       left,
  input  logic       right,
  input  logic       drop,
  input  logic       clear,
  input  logic       drop_ready,
  output logic       sel0,
  output logic       sel1,
  output logic       player,
  output logic       drop_valid,
  output logic [1:0] drop_col,
  output logic [2:0] drop_row,
  output logic       drop_err,
  output logic       game_full
);
  typedef enum logic [1:0] {IDLE, PLACE, DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      cursor, cursor_nx;
  logic            player_nx, valid_nx, err_nx;
  logic [1:0]      col_nx;
  logic [2:0]      row_nx;
  logic            prev_left, prev_right, prev_drop;
  logic            left_ev, right_ev, drop_ev;
  logic [3:0]      inc;
  logic [3:0][2:0] height;
  logic            full_after;

  assign sel0 = cursor[1];
  assign sel1 = cursor[0];

  assign left_ev  = left  & ~prev_left;
  assign right_ev = right & ~prev_right;
  assign drop_ev  = drop  & ~prev_drop;

  for (genvar c = 0; c < 4; c++) begin : g_col
    drop_col_height #(.ROWS(ROWS)) u_height (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .inc     (inc[c]),
      .count   (height[c])
    );
  end

  // Board is full after this commit if every column reaches ROWS counting the piece in flight.
  always_comb begin
    full_after = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if ({1'b0, height[c]} + {3'b000, (drop_col == 2'(c))} != 4'(ROWS))
        full_after = 1'b0;
    end
  end

  always_comb begin
    state_nx  = state;
    cursor_nx = cursor;
    player_nx = player;
    valid_nx  = drop_valid;
    col_nx    = drop_col;
    row_nx    = drop_row;
    err_nx    = 1'b0;
    inc       = 4'b0000;
    if (clear) begin
      state_nx  = IDLE;
      cursor_nx = 2'd0;
      player_nx = 1'b0;
      valid_nx  = 1'b0;
      col_nx    = 2'd0;
      row_nx    = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (drop_ev) begin
            if (height[cursor] < 3'(ROWS)) begin
              state_nx = PLACE;
              valid_nx = 1'b1;
              col_nx   = cursor;
              row_nx   = height[cursor];
            end else begin
              err_nx = 1'b1;
            end
          end else if (left_ev && !right_ev) begin
            cursor_nx = cursor - 2'd1;
          end else if (right_ev && !left_ev) begin
            cursor_nx = cursor + 2'd1;
          end
        end
        PLACE: begin
          if (drop_ready) begin
            inc[drop_col] = 1'b1;
            player_nx     = ~player;
            valid_nx      = 1'b0;
            state_nx      = full_after ? DONE : IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cursor     <= 2'd0;
      player     <= 1'b0;
      drop_valid <= 1'b0;
      drop_col   <= 2'd0;
      drop_row   <= 3'd0;
      drop_err   <= 1'b0;
      game_full  <= 1'b0;
      // Held buttons must not fire an event when reset is released.
      prev_left  <= 1'b1;
      prev_right <= 1'b1;
      prev_drop  <= 1'b1;
    end else begin
      state      <= state_nx;
      cursor     <= cursor_nx;
      player     <= player_nx;
      drop_valid <= valid_nx;
      drop_col   <= col_nx;
      drop_row   <= row_nx;
      drop_err   <= err_nx;
      game_full  <= (state_nx == DONE);
      prev_left  <= left;
      prev_right <= right;
      prev_drop  <= drop;
    end
  end
endmodule
